// File: rtl/matrix_operand_loader_if.sv
// matrix_operand_loader_if
//   Bundles the element stream, the operand-set output and the error pulses of
//   matrix_operand_loader.
//   Element stream : s_valid, s_ready, s_data, s_last, s_op
//   Operand set    : m_valid, m_ready, m_op, m_a, m_b, m_a_mul, m_b_mul
//   Error pulses   : err_frame, err_op, err_range
//   Modports: slave  = the loader itself
//             master = element source plus downstream arithmetic stage
interface matrix_operand_loader_if;
   logic        s_valid;
   logic        s_ready;
   logic [2:0]  s_data;
   logic        s_last;
   logic [1:0]  s_op;
   logic        m_valid;
   logic        m_ready;
   logic [1:0]  m_op;
   logic [11:0] m_a;
   logic [11:0] m_b;
   logic [7:0]  m_a_mul;
   logic [7:0]  m_b_mul;
   logic        err_frame;
   logic        err_op;
   logic        err_range;

   modport slave (
      input  s_valid, s_data, s_last, s_op, m_ready,
      output s_ready, m_valid, m_op, m_a, m_b, m_a_mul, m_b_mul,
             err_frame, err_op, err_range
   );

   modport master (
      output s_valid, s_data, s_last, s_op, m_ready,
      input  s_ready, m_valid, m_op, m_a, m_b, m_a_mul, m_b_mul,
             err_frame, err_op, err_range
   );
endinterface

// File: rtl/matrix_operand_loader.sv
// matrix_operand_loader
//   Collects eight 3-bit elements (a11,a12,a21,a22,b11,b12,b21,b22) plus an op
//   code per frame and presents them as one operand set, in both 3-bit and
//   2-bit-per-element packings. An assembly buffer and an output register give
//   double buffering: one frame can wait in PEND while another is presented.
//   Ports:
//     clk   : rising-edge clock
//     rst_n : asynchronous active-low reset
//     bus   : matrix_operand_loader_if.slave (stream in, operand set out, errors)
//   Optional feature: define MATLOAD_RANGE_CHECK_EN to drop mul frames holding
//   any element above 3 (reported on err_range).
module matrix_operand_loader (
   input  logic                   clk,
   input  logic                   rst_n,
   matrix_operand_loader_if.slave bus
);
   localparam int unsigned EW = 3;

   typedef enum logic [1:0] {StCollect, StDiscard, StPend} state_e;

   state_e        state_q, state_d;
   logic [2:0]    idx_q;
   logic [1:0]    op_q;
   logic [EW-1:0] buf_q [8];
   logic          m_valid_q;
   logic [1:0]    m_op_q;
   logic [11:0]   m_a_q, m_b_q;
   logic          err_frame_q, err_op_q, err_range_q;
   logic          err_frame_d, err_op_d, err_range_d;

   logic s_rdy, accept, complete, keep_frame, can_load, range_bad;
   logic load_direct, load_pend;

   assign s_rdy  = (state_q != StPend);
   assign accept = bus.s_valid && s_rdy;

   // Beat 7 with s_last closes a well-formed frame; op_q was captured on beat 0.
   assign complete   = accept && (state_q == StCollect) && (idx_q == 3'd7) && bus.s_last;
   assign keep_frame = complete && (op_q != 2'd3) && !range_bad;
   assign can_load   = !m_valid_q || bus.m_ready;

`ifdef MATLOAD_RANGE_CHECK_EN
   // Beat 7 is still on s_data when the frame completes.
   always_comb begin
      range_bad = 1'b0;
      if (op_q == 2'd2) begin
         for (int i = 0; i < 7; i++) begin
            if (buf_q[i] > 3'd3) range_bad = 1'b1;
         end
         if (bus.s_data > 3'd3) range_bad = 1'b1;
      end
   end
`else
   assign range_bad = 1'b0;
`endif

   // State register
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state_q <= StCollect;
      else        state_q <= state_d;
   end

   // Next-state logic
   always_comb begin
      state_d = state_q;
      unique case (state_q)
         StCollect: begin
            if (accept && (idx_q == 3'd7) && !bus.s_last) state_d = StDiscard;
            else if (keep_frame && !can_load)             state_d = StPend;
         end
         StDiscard: if (accept && bus.s_last)             state_d = StCollect;
         StPend:    if (bus.m_ready && m_valid_q)         state_d = StCollect;
         default:                                         state_d = StCollect;
      endcase
   end

   // Output / control decode
   always_comb begin
      load_direct = 1'b0;
      load_pend   = 1'b0;
      err_frame_d = 1'b0;
      err_op_d    = 1'b0;
      err_range_d = 1'b0;
      unique case (state_q)
         StCollect: begin
            if (accept) begin
               if (idx_q != 3'd7)        err_frame_d = bus.s_last;
               else if (!bus.s_last)     err_frame_d = 1'b1;
               else if (op_q == 2'd3)    err_op_d    = 1'b1;
               else if (range_bad)       err_range_d = 1'b1;
               else                      load_direct = can_load;
            end
         end
         StPend:  load_pend = bus.m_ready && m_valid_q;
         default: ;
      endcase
   end

   // Assembly buffer, output register and error pulses
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         idx_q       <= '0;
         op_q        <= '0;
         for (int i = 0; i < 8; i++) buf_q[i] <= '0;
         m_valid_q   <= 1'b0;
         m_op_q      <= '0;
         m_a_q       <= '0;
         m_b_q       <= '0;
         err_frame_q <= 1'b0;
         err_op_q    <= 1'b0;
         err_range_q <= 1'b0;
      end else begin
         err_frame_q <= err_frame_d;
         err_op_q    <= err_op_d;
         err_range_q <= err_range_d;

         if (accept && (state_q == StCollect)) begin
            buf_q[idx_q] <= bus.s_data;
            if (idx_q == 3'd0) op_q <= bus.s_op;
            idx_q <= (bus.s_last || (idx_q == 3'd7)) ? 3'd0 : idx_q + 3'd1;
         end

         if (load_direct) begin
            m_op_q <= op_q;
            m_a_q  <= {buf_q[0], buf_q[1], buf_q[2], buf_q[3]};
            m_b_q  <= {buf_q[4], buf_q[5], buf_q[6], bus.s_data};
         end else if (load_pend) begin
            m_op_q <= op_q;
            m_a_q  <= {buf_q[0], buf_q[1], buf_q[2], buf_q[3]};
            m_b_q  <= {buf_q[4], buf_q[5], buf_q[6], buf_q[7]};
         end

         if (load_direct || load_pend) m_valid_q <= 1'b1;
         else if (bus.m_ready)         m_valid_q <= 1'b0;
      end
   end

   assign bus.s_ready   = s_rdy;
   assign bus.m_valid   = m_valid_q;
   assign bus.m_op      = m_op_q;
   assign bus.m_a       = m_a_q;
   assign bus.m_b       = m_b_q;
   assign bus.m_a_mul   = {m_a_q[10:9], m_a_q[7:6], m_a_q[4:3], m_a_q[1:0]};
   assign bus.m_b_mul   = {m_b_q[10:9], m_b_q[7:6], m_b_q[4:3], m_b_q[1:0]};
   assign bus.err_frame = err_frame_q;
   assign bus.err_op    = err_op_q;
   assign bus.err_range = err_range_q;
endmodule

// File: tb/tb_matrix_operand_loader.sv
// tb_matrix_operand_loader
//   Scoreboard bench: each issued frame pushes its expected outcome (operand
//   set or error kind) into a queue; a monitor pops and compares whenever the
//   DUT presents an operand set or an error pulse.
module tb_matrix_operand_loader;
`ifdef MATLOAD_RANGE_CHECK_EN
   localparam bit RANGE = 1'b1;
`else
   localparam bit RANGE = 1'b0;
`endif

   typedef struct packed {
      logic [1:0]  op;
      logic [11:0] a;
      logic [11:0] b;
      logic [7:0]  am;
      logic [7:0]  bm;
   } exp_t;

   logic clk = 1'b0;
   logic rst_n;
   always #5 clk = ~clk;

   matrix_operand_loader_if bus ();
   matrix_operand_loader dut (.clk(clk), .rst_n(rst_n), .bus(bus));

   exp_t exp_q[$];
   int   err_q[$];
   int   n_cmp = 0;
   int   n_mis = 0;
   int   cyc = 0;
   int   mr_mode = 0;   // 0: m_ready=1, 1: random, 2: mr_force
   bit   mr_force = 1'b0;
   bit   gaps = 1'b0;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_mis++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   function automatic int el_at(input logic [23:0] el, input int i);
      return int'(el >> (21 - 3 * i)) % 8;
   endfunction

   // m_ready driver; applied 2 time units after the edge
   initial begin
      bus.m_ready = 1'b1;
      forever begin
         @(posedge clk);
         #2;
         if (mr_mode == 0)      bus.m_ready = 1'b1;
         else if (mr_mode == 1) bus.m_ready = 1'($urandom_range(0, 1));
         else                   bus.m_ready = mr_force;
      end
   end

   // Monitor
   initial begin
      exp_t e;
      int   k;
      forever begin
         @(negedge clk);
         if (rst_n === 1'b1) begin
            if (bus.m_valid) begin
               if (exp_q.size() == 0) begin
                  check("unexpected_m_valid", 32'(bus.m_valid), 0);
               end else begin
                  e = exp_q[0];
                  check("m_op", 32'(bus.m_op), 32'(e.op));
                  check("m_a", 32'(bus.m_a), 32'(e.a));
                  check("m_b", 32'(bus.m_b), 32'(e.b));
                  check("m_a_mul", 32'(bus.m_a_mul), 32'(e.am));
                  check("m_b_mul", 32'(bus.m_b_mul), 32'(e.bm));
                  if (bus.m_ready) void'(exp_q.pop_front());
               end
            end
            k = bus.err_frame ? 1 : bus.err_op ? 2 : bus.err_range ? 3 : 0;
            if (k != 0) begin
               if (err_q.size() == 0) check("unexpected_err_kind", 32'(k), 0);
               else                   check("err_kind", 32'(k), 32'(err_q.pop_front()));
            end
         end
      end
   end

   task automatic send_beat(input logic [2:0] d, input logic l, input logic [1:0] o);
      int   n = 0;
      logic rdy;
      if (gaps) repeat ($urandom_range(0, 2)) begin @(posedge clk); #1; end
      bus.s_valid = 1'b1;
      bus.s_data  = d;
      bus.s_last  = l;
      bus.s_op    = o;
      do begin
         @(negedge clk);
         rdy = bus.s_ready;
         @(posedge clk);
         #1;
         n++;
      end while (!rdy && n < 300);
      if (!rdy) check("accept_timeout", 32'(rdy), 1);
      bus.s_valid = 1'b0;
   endtask

   // kind 0: clean 8-beat frame; 1: s_last on beat arg; 2: 8+arg beats
   task automatic send_frame(input int kind, input logic [1:0] op, input logic [23:0] el,
                             input int arg, input bit chk_lat);
      int   nb;
      bit   big;
      exp_t e;
      nb = (kind == 1) ? arg + 1 : (kind == 2) ? 8 + arg : 8;
      big = 1'b0;
      for (int i = 0; i < 8; i++) if (el_at(el, i) > 3) big = 1'b1;
      if (kind != 0)                          err_q.push_back(1);
      else if (op == 2'd3)                    err_q.push_back(2);
      else if (RANGE && op == 2'd2 && big)    err_q.push_back(3);
      else begin
         e.op = op;
         e.a  = 12'(el_at(el, 0) * 512 + el_at(el, 1) * 64 + el_at(el, 2) * 8 + el_at(el, 3));
         e.b  = 12'(el_at(el, 4) * 512 + el_at(el, 5) * 64 + el_at(el, 6) * 8 + el_at(el, 7));
         e.am = 8'((el_at(el, 0) % 4) * 64 + (el_at(el, 1) % 4) * 16 +
                   (el_at(el, 2) % 4) * 4 + el_at(el, 3) % 4);
         e.bm = 8'((el_at(el, 4) % 4) * 64 + (el_at(el, 5) % 4) * 16 +
                   (el_at(el, 6) % 4) * 4 + el_at(el, 7) % 4);
         exp_q.push_back(e);
      end
      for (int i = 0; i < nb; i++) begin
         send_beat((i < 8) ? 3'(el_at(el, i)) : 3'($urandom_range(0, 7)),
                   (i == nb - 1), (i == 0) ? op : 2'($urandom_range(0, 3)));
      end
      if (chk_lat) check("latency_m_valid", 32'(bus.m_valid), 1);
   endtask

   task automatic wait_drain();
      int n = 0;
      while ((exp_q.size() != 0 || err_q.size() != 0) && n < 300) begin
         @(posedge clk);
         #1;
         n++;
      end
      check("drain_in_time", 32'(n < 300), 1);
   endtask

   task automatic check_reset();
      check("rst_s_ready", 32'(bus.s_ready), 1);
      check("rst_m_valid", 32'(bus.m_valid), 0);
      check("rst_m_op", 32'(bus.m_op), 0);
      check("rst_m_a", 32'(bus.m_a), 0);
      check("rst_m_b", 32'(bus.m_b), 0);
      check("rst_m_a_mul", 32'(bus.m_a_mul), 0);
      check("rst_m_b_mul", 32'(bus.m_b_mul), 0);
      check("rst_err_frame", 32'(bus.err_frame), 0);
      check("rst_err_op", 32'(bus.err_op), 0);
      check("rst_err_range", 32'(bus.err_range), 0);
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog");
   end

   initial begin
      int          t0;
      int          k;
      logic [1:0]  op;
      logic [23:0] el;
      rst_n       = 1'b0;
      bus.s_valid = 1'b0;
      bus.s_data  = '0;
      bus.s_last  = 1'b0;
      bus.s_op    = '0;
      repeat (3) @(posedge clk);
      #1;
      check_reset();
      rst_n = 1'b1;
      @(posedge clk);
      #1;

      // Add frame, mul frame
      send_frame(0, 2'd0, {3'd2, 3'd3, 3'd4, 3'd5, 3'd1, 3'd2, 3'd3, 3'd4}, 0, 1'b1);
      send_frame(0, 2'd2, {3'd0, 3'd1, 3'd2, 3'd3, 3'd1, 3'd0, 3'd3, 3'd1}, 0, 1'b1);
      wait_drain();

      // Throughput: two back-to-back frames, no idle cycles
      t0 = cyc;
      send_frame(0, 2'd1, 24'h5A3C71, 0, 1'b0);
      send_frame(0, 2'd0, 24'h1B2E94, 0, 1'b0);
      check("throughput_cycles", 32'(cyc - t0), 16);
      wait_drain();

      // Backpressure
      mr_force = 1'b0;
      mr_mode  = 2;
      @(posedge clk);
      #1;
      send_frame(0, 2'd0, 24'h123456, 0, 1'b0);
      check("bp_sready_frame1", 32'(bus.s_ready), 1);
      send_frame(0, 2'd1, 24'hFEDCBA, 0, 1'b0);
      check("bp_sready_pend", 32'(bus.s_ready), 0);
      repeat (3) begin @(posedge clk); #1; end
      check("bp_held_valid", 32'(bus.m_valid), 1);
      mr_force = 1'b1;
      @(posedge clk);
      #1;
      mr_force = 1'b0;
      @(posedge clk);
      #1;
      check("bp_reload_valid", 32'(bus.m_valid), 1);
      check("bp_sready_back", 32'(bus.s_ready), 1);
      mr_mode = 0;
      wait_drain();

      // Framing errors then a clean frame
      send_frame(1, 2'd0, 24'h777777, 4, 1'b0);
      check("early_last_no_valid", 32'(bus.m_valid), 0);
      send_frame(2, 2'd1, 24'h246135, 1, 1'b0);
      send_frame(0, 2'd1, 24'h246135, 0, 1'b1);
      wait_drain();

      // Reserved op
      send_frame(0, 2'd3, 24'h0F0F0F, 0, 1'b0);
      check("op3_no_valid", 32'(bus.m_valid), 0);
      wait_drain();

      // Reset mid-frame
      for (int i = 0; i < 4; i++) send_beat(3'(i + 1), 1'b0, 2'd0);
      rst_n = 1'b0;
      #1;
      check_reset();
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      send_frame(0, 2'd0, 24'h3D5A21, 0, 1'b1);
      wait_drain();

      // Reset while a frame is pending
      mr_force = 1'b0;
      mr_mode  = 2;
      @(posedge clk);
      #1;
      send_frame(0, 2'd0, 24'h111111, 0, 1'b0);
      send_frame(0, 2'd1, 24'h222222, 0, 1'b0);
      check("pend_sready", 32'(bus.s_ready), 0);
      rst_n = 1'b0;
      #1;
      check_reset();
      exp_q.delete();
      @(posedge clk);
      #1;
      rst_n   = 1'b1;
      mr_mode = 0;
      @(posedge clk);
      #1;

      // Mul frame with a11=5: range drop or low-bit truncation
      send_frame(0, 2'd2, {3'd5, 3'd1, 3'd2, 3'd3, 3'd1, 3'd0, 3'd3, 3'd1}, 0, 1'b0);
      wait_drain();

      // Randomized traffic
      mr_mode = 1;
      gaps    = 1'b1;
      for (int f = 0; f < 40; f++) begin
         k  = $urandom_range(0, 9);
         op = 2'($urandom_range(0, 3));
         el = 24'($urandom);
         if (k < 6)      send_frame(0, op, el, 0, 1'b0);
         else if (k < 8) send_frame(1, op, el, $urandom_range(0, 6), 1'b0);
         else            send_frame(2, op, el, $urandom_range(1, 3), 1'b0);
      end
      mr_mode = 0;
      gaps    = 1'b0;
      wait_drain();
      repeat (4) begin @(posedge clk); #1; end
      check("leftover_expected", 32'(exp_q.size() + err_q.size()), 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
      $finish;
   end
endmodule
